// File: rtl/host_csr_fifo_bank.sv
// rtl/host_csr_fifo_bank.sv - host CSR target: RW control registers plus PS->PL and PL->PS FIFOs
//
// Purpose: sits downstream of the AXI-Lite client adaptor. It accepts one request at a time and
// returns exactly one response per request. The response is valid one cycle after the request is
// accepted.
//
// Ports:
//   clk_i, reset_i                      clock and asynchronous active-high reset
//   v_i/ready_and_o, addr_i, wr_en_i,   request stream; the byte address is decoded on addr_i[11:0]
//   data_size_i, wdata_i
//   v_o/ready_and_i, rdata_o            response stream; rdata_o is 0 on write responses
//   regs_o                              control register contents, reg0 in the LSBs
//   pl_v_o, pl_data_o, pl_yumi_i        head of the PS->PL FIFO and its dequeue strobe
//   pl_v_i, pl_data_i, pl_ready_and_o   enqueue side of the PL->PS FIFO
//
// Optional build macro: HOST_CSR_BANK_CYCLE_CTR_EN adds a 64-bit cycle counter at 0x118/0x11C.
module host_csr_fifo_bank #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32,
    parameter int num_regs_p   = 4,
    parameter int fifo_els_p   = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [addr_width_p-1:0]            addr_i,
    input  logic                               wr_en_i,
    input  logic [1:0]                         data_size_i,
    input  logic [data_width_p-1:0]            wdata_i,
    output logic                               v_o,
    input  logic                               ready_and_i,
    output logic [data_width_p-1:0]            rdata_o,
    output logic [num_regs_p*data_width_p-1:0] regs_o,
    output logic                               pl_v_o,
    output logic [data_width_p-1:0]            pl_data_o,
    input  logic                               pl_yumi_i,
    input  logic                               pl_v_i,
    input  logic [data_width_p-1:0]            pl_data_i,
    output logic                               pl_ready_and_o
);
    localparam int bytes_lp = data_width_p / 8;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

    typedef enum logic {e_ready, e_resp} state_e;
    state_e state_r, state_n;

    logic [11:0] a;
    logic        unused_addr;
    assign a           = addr_i[11:0];
    assign unused_addr = ^addr_i[addr_width_p-1:12];

    logic accept, wr_acc, rd_acc;
    assign ready_and_o = (state_r == e_ready);
    assign v_o         = (state_r == e_resp);
    assign accept      = v_i & ready_and_o;
    assign wr_acc      = accept & wr_en_i;
    assign rd_acc      = accept & ~wr_en_i;

    logic hit_ps_data, hit_ps_free, hit_pp_data, hit_pp_occ, hit_status;
    assign hit_ps_data = (a == 12'h100);
    assign hit_ps_free = (a == 12'h104);
    assign hit_pp_data = (a == 12'h108);
    assign hit_pp_occ  = (a == 12'h10C);
    assign hit_status  = (a == 12'h110);

    // FSM: one outstanding request, the response is held until the host takes it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_ready;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready: if (accept)      state_n = e_resp;
            e_resp:  if (ready_and_i) state_n = e_ready;
            default:                  state_n = e_ready;
        endcase
    end

    // Byte mask covering the low 2^data_size_i bytes; sizes wider than the bus saturate to all bytes
    logic [bytes_lp-1:0]     byte_mask;
    logic [data_width_p-1:0] wmask;
    always_comb begin
        byte_mask = '0;
        wmask     = '0;
        for (int b = 0; b < bytes_lp; b++) begin
            if (b < (1 << data_size_i)) byte_mask[b] = 1'b1;
            wmask[b*8 +: 8] = {8{byte_mask[b]}};
        end
    end

    // Control registers
    logic [data_width_p-1:0] regs_r [num_regs_p];
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_regs_p; i++) regs_r[i] <= '0;
        end else begin
            for (int i = 0; i < num_regs_p; i++)
                if (wr_acc && (a == 12'(4*i)))
                    regs_r[i] <= (regs_r[i] & ~wmask) | (wdata_i & wmask);
        end
    end

    for (genvar g = 0; g < num_regs_p; g++) begin : g_regs_o
        assign regs_o[g*data_width_p +: data_width_p] = regs_r[g];
    end

    // PS->PL FIFO: host writes enqueue, the PL dequeues with pl_yumi_i.
    // Fullness is judged on the count at cycle start, so a same-cycle dequeue never makes room.
    logic [data_width_p-1:0] ps_mem [fifo_els_p];
    logic [ptr_w_lp-1:0]     ps_wptr, ps_rptr;
    logic [cnt_w_lp-1:0]     ps_cnt;
    logic                    ps_enq, ps_deq, ps_ovf;
    assign ps_enq    = wr_acc & hit_ps_data & (ps_cnt != full_cnt_lp);
    assign ps_ovf    = wr_acc & hit_ps_data & (ps_cnt == full_cnt_lp);
    assign ps_deq    = pl_yumi_i & (ps_cnt != '0);
    assign pl_v_o    = (ps_cnt != '0);
    assign pl_data_o = pl_v_o ? ps_mem[ps_rptr] : '0;

    // PL->PS FIFO: the PL enqueues, host reads of 0x108 dequeue
    logic [data_width_p-1:0] pp_mem [fifo_els_p];
    logic [ptr_w_lp-1:0]     pp_wptr, pp_rptr;
    logic [cnt_w_lp-1:0]     pp_cnt;
    logic                    pp_enq, pp_deq, pp_unf;
    assign pl_ready_and_o = (pp_cnt != full_cnt_lp);
    assign pp_enq         = pl_v_i & pl_ready_and_o;
    assign pp_deq         = rd_acc & hit_pp_data & (pp_cnt != '0);
    assign pp_unf         = rd_acc & hit_pp_data & (pp_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (ps_enq) ps_mem[ps_wptr] <= wdata_i;
        if (pp_enq) pp_mem[pp_wptr] <= pl_data_i;
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ps_wptr <= '0; ps_rptr <= '0; ps_cnt <= '0;
            pp_wptr <= '0; pp_rptr <= '0; pp_cnt <= '0;
        end else begin
            if (ps_enq) ps_wptr <= ps_wptr + 1'b1;
            if (ps_deq) ps_rptr <= ps_rptr + 1'b1;
            if (ps_enq && !ps_deq)      ps_cnt <= ps_cnt + 1'b1;
            else if (!ps_enq && ps_deq) ps_cnt <= ps_cnt - 1'b1;
            if (pp_enq) pp_wptr <= pp_wptr + 1'b1;
            if (pp_deq) pp_rptr <= pp_rptr + 1'b1;
            if (pp_enq && !pp_deq)      pp_cnt <= pp_cnt + 1'b1;
            else if (!pp_enq && pp_deq) pp_cnt <= pp_cnt - 1'b1;
        end
    end

    // Sticky error status; a new error event outranks a same-cycle clear
    logic [1:0] status_r, status_clr;
    assign status_clr = (wr_acc && hit_status) ? wdata_i[1:0] : 2'b00;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) status_r <= 2'b00;
        else         status_r <= (status_r & ~status_clr) | {pp_unf, ps_ovf};
    end

`ifdef HOST_CSR_BANK_CYCLE_CTR_EN
    // High word is snapshotted on a low-word read so a low/high pair is coherent
    logic [63:0] ctr_r;
    logic [31:0] ctr_hi_snap_r;
    logic        hit_ctr_lo, hit_ctr_hi;
    assign hit_ctr_lo = (a == 12'h118);
    assign hit_ctr_hi = (a == 12'h11C);
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_r         <= '0;
            ctr_hi_snap_r <= '0;
        end else begin
            if (wr_acc && (hit_ctr_lo || hit_ctr_hi)) ctr_r <= '0;
            else                                      ctr_r <= ctr_r + 64'd1;
            if (rd_acc && hit_ctr_lo) ctr_hi_snap_r <= ctr_r[63:32];
        end
    end
`endif

    // Read data mux
    logic [data_width_p-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < num_regs_p; i++)
            if (a == 12'(4*i)) rd_val = regs_r[i];
        if (hit_ps_free) rd_val = data_width_p'(full_cnt_lp - ps_cnt);
        if (hit_pp_data) rd_val = (pp_cnt != '0) ? pp_mem[pp_rptr] : '0;
        if (hit_pp_occ)  rd_val = data_width_p'(pp_cnt);
        if (hit_status)  rd_val = data_width_p'(status_r);
`ifdef HOST_CSR_BANK_CYCLE_CTR_EN
        if (hit_ctr_lo)  rd_val = data_width_p'(ctr_r[31:0]);
        if (hit_ctr_hi)  rd_val = data_width_p'(ctr_hi_snap_r);
`endif
    end

    logic [data_width_p-1:0] rdata_r;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     rdata_r <= '0;
        else if (accept) rdata_r <= wr_en_i ? '0 : rd_val;
    end
    assign rdata_o = rdata_r;

endmodule

// File: tb/tb_host_csr_fifo_bank.sv
// tb/tb_host_csr_fifo_bank.sv - directed self-checking bench for host_csr_fifo_bank
module tb_host_csr_fifo_bank;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic        ready_and_o;
    logic [31:0] addr_i = '0;
    logic        wr_en_i = 1'b0;
    logic [1:0]  data_size_i = 2'd0;
    logic [31:0] wdata_i = '0;
    logic        v_o;
    logic        ready_and_i = 1'b1;
    logic [31:0] rdata_o;
    logic [127:0] regs_o;
    logic        pl_v_o;
    logic [31:0] pl_data_o;
    logic        pl_yumi_i = 1'b0;
    logic        pl_v_i = 1'b0;
    logic [31:0] pl_data_i = '0;
    logic        pl_ready_and_o;

    host_csr_fifo_bank dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .addr_i(addr_i), .wr_en_i(wr_en_i), .data_size_i(data_size_i), .wdata_i(wdata_i),
        .v_o(v_o), .ready_and_i(ready_and_i), .rdata_o(rdata_o), .regs_o(regs_o),
        .pl_v_o(pl_v_o), .pl_data_o(pl_data_o), .pl_yumi_i(pl_yumi_i),
        .pl_v_i(pl_v_i), .pl_data_i(pl_data_i), .pl_ready_and_o(pl_ready_and_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request with an immediately-taken response; checks the response arrives 1 cycle after accept
    task automatic xact(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk_i);
        v_i = 1'b1; addr_i = addr; wr_en_i = wr; data_size_i = size; wdata_i = wd;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        check_eq("resp_latency", {127'd0, v_o}, 128'd1);
        rd = rdata_o;
        @(posedge clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] dummy;
        xact(addr, 1'b1, size, wd, dummy);
        check_eq("wr_rdata_zero", {96'd0, dummy}, 128'd0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        xact(addr, 1'b0, 2'd2, 32'd0, r);
        check_eq(tag, {96'd0, r}, {96'd0, exp});
    endtask

    logic [31:0] c0, c1;

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_ready", {127'd0, ready_and_o}, 128'd1);
        check_eq("rst_v_o", {127'd0, v_o}, 128'd0);
        check_eq("rst_rdata", {96'd0, rdata_o}, 128'd0);
        check_eq("rst_regs", regs_o, 128'd0);
        check_eq("rst_pl_v", {127'd0, pl_v_o}, 128'd0);
        check_eq("rst_pl_data", {96'd0, pl_data_o}, 128'd0);
        check_eq("rst_pl_ready", {127'd0, pl_ready_and_o}, 128'd1);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Register writes and byte masking
        wr(32'h004, 2'd2, 32'hA5A5_1234);
        rd_check("reg1_rd", 32'h004, 32'hA5A5_1234);
        check_eq("regs_o_reg1", {96'd0, regs_o[63:32]}, 128'hA5A5_1234);
        wr(32'h000, 2'd2, 32'h1122_3344);
        wr(32'h000, 2'd0, 32'hAABB_CCFF);
        rd_check("reg0_byte", 32'h000, 32'h1122_33FF);
        wr(32'h000, 2'd1, 32'hDEAD_BEEF);
        rd_check("reg0_half", 32'h000, 32'h1122_BEEF);
        wr(32'hF000_0008, 2'd3, 32'hCAFE_F00D);
        rd_check("reg2_hiaddr_wide", 32'h008, 32'hCAFE_F00D);
        check_eq("regs_o_all", regs_o, {32'd0, 32'hCAFE_F00D, 32'hA5A5_1234, 32'h1122_BEEF});
        rd_check("unmapped_rd", 32'h200, 32'd0);
        wr(32'h104, 2'd2, 32'h5);
        rd_check("ro_write_ignored", 32'h104, 32'd8);

        // PS->PL overflow
        for (int i = 1; i <= 9; i++) wr(32'h100, 2'd2, i);
        rd_check("ps_free_full", 32'h104, 32'd0);
        rd_check("status_ovf", 32'h110, 32'h1);
        check_eq("pl_v_full", {127'd0, pl_v_o}, 128'd1);
        check_eq("pl_head1", {96'd0, pl_data_o}, 128'd1);
        wr(32'h110, 2'd2, 32'h1);
        rd_check("status_clr", 32'h110, 32'h0);
        @(negedge clk_i); pl_yumi_i = 1'b1;
        @(posedge clk_i); #1; pl_yumi_i = 1'b0;
        check_eq("pl_head2", {96'd0, pl_data_o}, 128'd2);
        rd_check("ps_free_one", 32'h104, 32'd1);

        // PL->PS push then drain past empty
        @(negedge clk_i); pl_v_i = 1'b1; pl_data_i = 32'h10;
        @(negedge clk_i); pl_data_i = 32'h20;
        @(negedge clk_i); pl_v_i = 1'b0;
        rd_check("pp_occ2", 32'h10C, 32'd2);
        rd_check("pp_pop0", 32'h108, 32'h10);
        rd_check("pp_pop1", 32'h108, 32'h20);
        rd_check("pp_pop_empty", 32'h108, 32'h0);
        rd_check("status_unf", 32'h110, 32'h2);
        rd_check("pp_occ0", 32'h10C, 32'd0);

        // Response back-pressure, then async reset mid-hold
        @(negedge clk_i);
        ready_and_i = 1'b0; v_i = 1'b1; addr_i = 32'h004; wr_en_i = 1'b0;
        @(posedge clk_i); #1; v_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_v_o", {127'd0, v_o}, 128'd1);
            check_eq("hold_rdata", {96'd0, rdata_o}, 128'hA5A5_1234);
            check_eq("hold_ready", {127'd0, ready_and_o}, 128'd0);
            @(posedge clk_i); #1;
        end
        #2 reset_i = 1'b1;
        #1;
        check_eq("async_rst_v_o", {127'd0, v_o}, 128'd0);
        check_eq("async_rst_ready", {127'd0, ready_and_o}, 128'd1);
        check_eq("async_rst_regs", regs_o, 128'd0);
        check_eq("async_rst_rdata", {96'd0, rdata_o}, 128'd0);
        @(negedge clk_i);
        reset_i = 1'b0; ready_and_i = 1'b1;
        rd_check("post_rst_status", 32'h110, 32'h0);

        // Cycle counter: accepts are 7 cycles apart
`ifdef HOST_CSR_BANK_CYCLE_CTR_EN
        xact(32'h118, 1'b0, 2'd2, 32'd0, c0);
        repeat (5) @(posedge clk_i);
        xact(32'h118, 1'b0, 2'd2, 32'd0, c1);
        check_eq("ctr_delta", {96'd0, c1 - c0}, 128'd7);
        rd_check("ctr_hi_snap", 32'h11C, 32'd0);
`else
        xact(32'h118, 1'b0, 2'd2, 32'd0, c0);
        check_eq("ctr_absent_lo", {96'd0, c0}, 128'd0);
        xact(32'h11C, 1'b0, 2'd2, 32'd0, c1);
        check_eq("ctr_absent_hi", {96'd0, c1}, 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
